// File: rtl/switch_key_reader_pkg.sv
// Shared register map and CTRL field layout for the switch/key input peripheral.
package switch_key_reader_pkg;

  // Register select taken from Addr[3:2].
  typedef enum logic [1:0] {
    REG_SW   = 2'd0,
    REG_KEY  = 2'd1,
    REG_EVT  = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_MASK_LSB = 8;

  // Expands the four byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/switch_key_reader_input_debouncer.sv
// Per-bit 2-flop synchronizer plus tick-sampled history debouncer with a
// stable level output and a one-cycle rising-edge flag aligned to the update.
module switch_key_reader_input_debouncer #(
  parameter int W        = 8,
  parameter int DB_DEPTH = 4,
  parameter bit INVERT   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0]                sync1_q, sync2_q;
  logic [W-1:0]                level;
  logic [W-1:0][DB_DEPTH-1:0]  hist_q, hist_d;
  logic [W-1:0]                stable_q, stable_d;

  // Synchronizers idle at the input's released level, so leaving reset never
  // presents a false active sample to the history.
  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {W{INVERT}};
      sync2_q <= {W{INVERT}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign level = INVERT ? ~sync2_q : sync2_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hist_d   = hist_q;
    stable_d = stable_q;
    if (tick_i) begin
      for (int i = 0; i < W; i++) begin
        hist_d[i] = {hist_q[i][DB_DEPTH-2:0], level[i]};
        if (&hist_d[i]) begin
          stable_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          stable_d[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: histories are real reset flops, not RAM, so a reset mid-debounce drops partial runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      stable_q <= '0;
    end else begin
      hist_q   <= hist_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/switch_key_reader.sv
// Bus-readable DIP switch / push-key peripheral with sticky press events.
// Define SWITCH_KEY_IRQ_EN to build the CTRL register and the interrupt output.
module switch_key_reader
  import switch_key_reader_pkg::*;
#(
  parameter int SW_W     = 32,
  parameter int KEY_W    = 8,
  parameter int TICK_DIV = 500000,
  parameter int DB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr,
  input  logic              WE,
  input  logic [3:0]        byteen,
  input  logic [31:0]       WD,
  output logic [31:0]       O,
  input  logic [SW_W-1:0]   dip_switch,
  input  logic [KEY_W-1:0]  user_key,
  output logic              irq
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int MASK_W = (KEY_W < 24) ? KEY_W : 24;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  logic [SW_W-1:0]  sw_stable, sw_rise_unused;
  logic [KEY_W-1:0] key_stable, key_rise;

  switch_key_reader_input_debouncer #(
    .W(SW_W), .DB_DEPTH(DB_DEPTH), .INVERT(1'b0)
  ) u_sw_db (
    .clk(clk), .rst_n(reset), .tick_i(tick), .raw_i(dip_switch),
    .stable_o(sw_stable), .rise_o(sw_rise_unused)
  );

  // Keys are active-low on the pins; the debouncer hands back 1 = pressed.
  switch_key_reader_input_debouncer #(
    .W(KEY_W), .DB_DEPTH(DB_DEPTH), .INVERT(1'b1)
  ) u_key_db (
    .clk(clk), .rst_n(reset), .tick_i(tick), .raw_i(user_key),
    .stable_o(key_stable), .rise_o(key_rise)
  );

  reg_sel_e         sel;
  logic [31:0]      wmask;
  logic [KEY_W-1:0] evt_q, evt_d, evt_clr;
  logic [31:0]      ctrl_rd;

  assign sel   = reg_sel_e'(Addr[3:2]);
  assign wmask = lane_mask(byteen);

  // A press accepted in the same cycle as a clear wins over the clear.
  always_comb begin
    evt_clr = '0;
    if (WE && sel == REG_EVT) begin
      evt_clr = WD[KEY_W-1:0] & wmask[KEY_W-1:0];
    end
    evt_d = (evt_q & ~evt_clr) | key_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

`ifdef SWITCH_KEY_IRQ_EN
  localparam logic [31:0] CTRL_IMPL = (32'(1) << CTRL_IRQ_EN)
                                    | (((32'(1) << MASK_W) - 32'(1)) << CTRL_MASK_LSB);

  logic [31:0] ctrl_q, ctrl_d;
  logic        irq_q;

  always_comb begin
    ctrl_d = ctrl_q;
    if (WE && sel == REG_CTRL) begin
      ctrl_d = ((ctrl_q & ~wmask) | (WD & wmask)) & CTRL_IMPL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= ctrl_q[CTRL_IRQ_EN]
              & |(evt_q[MASK_W-1:0] & ctrl_q[CTRL_MASK_LSB +: MASK_W]);
    end
  end

  assign ctrl_rd = ctrl_q;
  assign irq     = irq_q;
`else
  assign ctrl_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    O = '0;
    case (sel)
      REG_SW:   O = 32'(sw_stable);
      REG_KEY:  O = 32'(key_stable);
      REG_EVT:  O = 32'(evt_q);
      REG_CTRL: O = ctrl_rd;
      default:  O = '0;
    endcase
  end

  // Address bits outside [3:2] and data/lane bits beyond the implemented fields are don't-care.
  logic unused_bits;
  assign unused_bits = &{1'b0, Addr[31:4], Addr[1:0], WD, wmask, sw_rise_unused};

endmodule

// File: tb/tb_switch_key_reader.sv
// Self-checking bench: randomized and directed stimulus against a queue-based
// model built from the debounce, event and register rules.
module tb_switch_key_reader;

  localparam int SW_W     = 32;
  localparam int KEY_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int DB_DEPTH = 4;
  localparam logic [1:0] R_SW = 2'd0, R_KEY = 2'd1, R_EVT = 2'd2, R_CTRL = 2'd3;
`ifdef SWITCH_KEY_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       Addr = '0;
  logic              WE = 1'b0;
  logic [3:0]        byteen = '0;
  logic [31:0]       WD = '0;
  logic [31:0]       O;
  logic [SW_W-1:0]   dip_switch = '0;
  logic [KEY_W-1:0]  user_key = '1;
  logic              irq;

  int n_pass = 0;
  int n_total = 0;

  switch_key_reader #(
    .SW_W(SW_W), .KEY_W(KEY_W), .TICK_DIV(TICK_DIV), .DB_DEPTH(DB_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .byteen(byteen), .WD(WD),
    .O(O), .dip_switch(dip_switch), .user_key(user_key), .irq(irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] sw_pipe[$], key_pipe[$];
  logic [31:0] sw_smp[$], key_smp[$], nx_sw_smp[$], nx_key_smp[$];
  logic [31:0] m_sw, nx_sw, m_ctrl, nx_ctrl;
  logic [KEY_W-1:0] m_key, nx_key, nx_rise, m_evt, nx_evt;
  logic m_irq, nx_irq;
  int m_edges;
  logic [31:0] edge_sw, edge_key;

  // A bit is accepted once every retained sample agrees; otherwise it keeps its old value.
  function automatic logic [31:0] settle(input logic [31:0] smp[$], input logic [31:0] prev);
    logic [31:0] all1, any1;
    all1 = '1;
    any1 = '0;
    foreach (smp[k]) begin
      all1 &= smp[k];
      any1 |= smp[k];
    end
    return all1 | (prev & any1);
  endfunction

  task automatic model_reset();
    sw_pipe.delete(); key_pipe.delete(); sw_smp.delete(); key_smp.delete();
    repeat (2) begin sw_pipe.push_back('0); key_pipe.push_back('0); end
    repeat (DB_DEPTH) begin sw_smp.push_back('0); key_smp.push_back('0); end
    m_sw = '0; m_key = '0; m_evt = '0; m_ctrl = '0; m_irq = 1'b0; m_edges = 0;
  endtask

  task automatic model_next();
    logic [31:0] lanes, clr;
    nx_sw_smp = sw_smp;
    nx_key_smp = key_smp;
    nx_sw = m_sw;
    nx_key = m_key;
    if (m_edges % TICK_DIV == TICK_DIV - 1) begin
      nx_sw_smp.push_back(sw_pipe[0]);   void'(nx_sw_smp.pop_front());
      nx_key_smp.push_back(key_pipe[0]); void'(nx_key_smp.pop_front());
      nx_sw  = settle(nx_sw_smp, m_sw);
      nx_key = KEY_W'(settle(nx_key_smp, 32'(m_key)));
    end
    nx_rise = nx_key & ~m_key;
    lanes = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    clr = (WE && Addr[3:2] == R_EVT) ? (WD & lanes) : 32'h0;
    nx_evt = (m_evt & ~KEY_W'(clr)) | nx_rise;
    nx_ctrl = m_ctrl;
    if (IRQ_BUILT && WE && Addr[3:2] == R_CTRL)
      nx_ctrl = ((m_ctrl & ~lanes) | (WD & lanes)) & 32'h0000_FF01;
    nx_irq = IRQ_BUILT && m_ctrl[0] && ((m_evt & m_ctrl[15:8]) != '0);
    edge_sw = 32'(dip_switch);
    edge_key = 32'(~user_key);
  endtask

  task automatic model_commit();
    sw_smp = nx_sw_smp;
    key_smp = nx_key_smp;
    void'(sw_pipe.pop_front());  sw_pipe.push_back(edge_sw);
    void'(key_pipe.pop_front()); key_pipe.push_back(edge_key);
    m_sw = nx_sw; m_key = nx_key; m_evt = nx_evt; m_ctrl = nx_ctrl; m_irq = nx_irq;
    m_edges++;
  endtask

  function automatic logic [31:0] exp_reg(input logic [1:0] r);
    case (r)
      R_SW:    return m_sw;
      R_KEY:   return 32'(m_key);
      R_EVT:   return 32'(m_evt);
      default: return m_ctrl;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_next();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    logic [31:0] junk;
    junk = $urandom();
    Addr = {junk[31:4], r, junk[1:0]};
    #1;
    v = O;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] junk;
    junk = $urandom();
    Addr = {junk[31:4], r, junk[1:0]};
    WD = d; byteen = be; WE = 1'b1;
    step();
    WE = 1'b0; WD = $urandom(); byteen = 4'($urandom());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      n_total++;
      if (v !== 32'h0) $display("FAIL reset_read reg=%0d got=%h exp=%h", r, v, 32'h0); else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_switches();
    logic [31:0] v;
    int first;
    first = -1;
    dip_switch = 32'hA5A5_0F0F;
    for (int i = 1; i <= 30; i++) begin
      step();
      rd(R_SW, v);
      n_total++;
      if (v !== m_sw) $display("FAIL sw_track cyc=%0d got=%h exp=%h", i, v, m_sw); else n_pass++;
      if (first < 0 && v != 32'h0) first = i;
    end
    n_total++;
    if (first < 14 || first > 18) $display("FAIL sw_latency got=%0d exp=14..18", first); else n_pass++;
    n_total++;
    if (v !== 32'hA5A5_0F0F) $display("FAIL sw_final got=%h exp=%h", v, 32'hA5A5_0F0F); else n_pass++;
    rd(R_EVT, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL sw_no_event got=%h exp=0", v); else n_pass++;
  endtask

  task automatic test_key_glitch();
    logic [31:0] vk, ve;
    for (int i = 0; i < 35; i++) begin
      user_key = (i < 5) ? 8'hF7 : 8'hFF;
      step();
      rd(R_KEY, vk);
      rd(R_EVT, ve);
      n_total++;
      if (vk !== exp_reg(R_KEY) || ve !== exp_reg(R_EVT))
        $display("FAIL glitch_track cyc=%0d got key=%h evt=%h exp key=%h evt=%h",
                 i, vk, ve, exp_reg(R_KEY), exp_reg(R_EVT));
      else n_pass++;
    end
    n_total++;
    if (vk !== 32'h0 || ve !== 32'h0) $display("FAIL glitch_final got key=%h evt=%h exp 0/0", vk, ve);
    else n_pass++;
  endtask

  task automatic test_key_press();
    logic [31:0] vk, ve, v;
    user_key = 8'hF7;
    for (int i = 0; i < 40; i++) begin
      step();
      rd(R_KEY, vk);
      n_total++;
      if (vk !== exp_reg(R_KEY)) $display("FAIL press_track cyc=%0d got=%h exp=%h", i, vk, exp_reg(R_KEY));
      else n_pass++;
    end
    rd(R_EVT, ve);
    n_total++;
    if (vk !== 32'h8 || ve !== 32'h8) $display("FAIL press_held got key=%h evt=%h exp 8/8", vk, ve); else n_pass++;
    user_key = 8'hFF;
    hold(30);
    rd(R_KEY, vk);
    rd(R_EVT, ve);
    n_total++;
    if (vk !== 32'h0 || ve !== 32'h8) $display("FAIL press_released got key=%h evt=%h exp 0/8", vk, ve); else n_pass++;
    bus_write(R_SW, 32'hFFFF_FFFF, 4'hF);
    rd(R_SW, v);
    n_total++;
    if (v !== 32'hA5A5_0F0F) $display("FAIL sw_write_ignored got=%h exp=%h", v, 32'hA5A5_0F0F); else n_pass++;
    bus_write(R_EVT, 32'h8, 4'hE);
    rd(R_EVT, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL w1c_lane_off got=%h exp=%h", v, 32'h8); else n_pass++;
    bus_write(R_EVT, 32'h8, 4'hF);
    rd(R_EVT, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL w1c_clear got=%h exp=0", v); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] v;
    int evt_cyc, irq_cyc, exp_cyc;
    bus_write(R_CTRL, 32'h0000_0801, 4'hF);
    rd(R_CTRL, v);
    n_total++;
    if (v !== (IRQ_BUILT ? 32'h0000_0801 : 32'h0)) $display("FAIL ctrl_read got=%h exp=%h", v, IRQ_BUILT ? 32'h801 : 32'h0);
    else n_pass++;
    user_key = 8'hF7;
    evt_cyc = -1;
    irq_cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      rd(R_EVT, v);
      if (evt_cyc < 0 && v[3]) evt_cyc = i;
      if (irq_cyc < 0 && irq === 1'b1) irq_cyc = i;
      n_total++;
      if (irq !== m_irq) $display("FAIL irq_track cyc=%0d got=%b exp=%b", i, irq, m_irq); else n_pass++;
    end
    exp_cyc = IRQ_BUILT ? evt_cyc + 1 : -1;
    n_total++;
    if (evt_cyc < 0 || irq_cyc != exp_cyc) $display("FAIL irq_rise got=%0d exp=%0d (evt at %0d)", irq_cyc, exp_cyc, evt_cyc);
    else n_pass++;
    user_key = 8'hFF;
    hold(30);
    bus_write(R_EVT, 32'h8, 4'hF);
    n_total++;
    if (irq !== IRQ_BUILT) $display("FAIL irq_hold_after_w1c got=%b exp=%b", irq, IRQ_BUILT); else n_pass++;
    step();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_drop got=%b exp=0", irq); else n_pass++;
    bus_write(R_CTRL, 32'h0000_0001, 4'hF);
    user_key = 8'hF7;
    for (int i = 0; i < 40; i++) begin
      step();
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_masked cyc=%0d got=%b exp=0", i, irq); else n_pass++;
    end
    user_key = 8'hFF;
    hold(30);
    bus_write(R_EVT, 32'hFF, 4'hF);
    bus_write(R_CTRL, 32'hFFFF_FFFF, 4'hF);
    rd(R_CTRL, v);
    n_total++;
    if (v !== (IRQ_BUILT ? 32'h0000_FF01 : 32'h0)) $display("FAIL ctrl_unimpl got=%h exp=%h", v, IRQ_BUILT ? 32'hFF01 : 32'h0);
    else n_pass++;
    bus_write(R_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] v, junk;
    bit hit;
    user_key = 8'hF7;
    hold(40);
    user_key = 8'hFF;
    hold(30);
    user_key = 8'hF7;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      model_next();
      if (nx_rise[3]) begin
        junk = $urandom();
        Addr = {junk[31:4], R_EVT, junk[1:0]};
        WD = 32'h8; byteen = 4'hF; WE = 1'b1;
        hit = 1'b1;
      end
      step();
      WE = 1'b0;
    end
    n_total++;
    if (!hit) $display("FAIL collision_timeout got=no_press exp=press within 40 cycles"); else n_pass++;
    rd(R_EVT, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL collision_set_wins got=%h exp=%h", v, 32'h8); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int rises;
    bit prev;
    bus_write(R_CTRL, 32'h0000_0801, 4'hF);
    user_key = 8'hFF;
    hold(30);
    user_key = 8'hF7;
    hold(6);
    reset = 1'b0;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      n_total++;
      if (v !== 32'h0) $display("FAIL async_reset_read reg=%0d got=%h exp=0", r, v); else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL async_reset_irq got=%b exp=0", irq); else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      rd(R_EVT, v);
      n_total++;
      if (v !== exp_reg(R_EVT)) $display("FAIL post_reset_track cyc=%0d got=%h exp=%h", i, v, exp_reg(R_EVT));
      else n_pass++;
      if (v[3] && !prev) rises++;
      prev = v[3];
    end
    n_total++;
    if (rises != 1) $display("FAIL post_reset_events got=%0d exp=1", rises); else n_pass++;
    bus_write(R_EVT, 32'h8, 4'hF);
    hold(40);
    rd(R_EVT, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL held_no_repeat got=%h exp=0", v); else n_pass++;
    user_key = 8'hFF;
    hold(30);
  endtask

  task automatic test_random();
    logic [31:0] v, junk;
    logic [1:0] r;
    int hold_sw, hold_key;
    hold_sw = 0;
    hold_key = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_sw == 0) begin dip_switch = $urandom(); hold_sw = $urandom_range(1, 30); end
      if (hold_key == 0) begin user_key = KEY_W'($urandom()); hold_key = $urandom_range(1, 40); end
      hold_sw--;
      hold_key--;
      if ($urandom_range(0, 9) == 0) begin
        junk = $urandom();
        r = 2'($urandom_range(0, 3));
        Addr = {junk[31:4], r, junk[1:0]};
        WD = $urandom(); byteen = 4'($urandom()); WE = 1'b1;
      end
      step();
      WE = 1'b0;
      r = 2'($urandom_range(0, 3));
      rd(r, v);
      n_total++;
      if (v !== exp_reg(r)) $display("FAIL random_read cyc=%0d reg=%0d got=%h exp=%h", i, r, v, exp_reg(r));
      else n_pass++;
      n_total++;
      if (irq !== m_irq) $display("FAIL random_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_switches();
    test_key_glitch();
    test_key_press();
    test_irq();
    test_w1c_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_key_reader.md
Name: switch_key_reader

Overview:
- Bus-readable input peripheral on the CPU's memory-mapped I/O bus. It is the input-side counterpart of the write-only display peripheral.
- Samples board DIP switches and push keys, synchronizes and debounces them, and records key-press events in a sticky register.
- Raises an interrupt request when an enabled key-press event is pending.
- Sits behind the system bridge alongside the timer and display peripherals.

Parameters:
- SW_W, 32, number of DIP switch inputs; must be ≤32.
- KEY_W, 8, number of push-key inputs; must be ≤32.
- TICK_DIV, 500000, clk cycles between debounce samples; minimum 2.
- DB_DEPTH, 4, consecutive equal samples required to accept a new level; minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; block is held in reset while reset==0
- Addr  input  32  byte address; only Addr[3:2] decoded
- WE  input  1  write enable, valid for one clk per bus write
- byteen  input  4  byte lanes for the write
- WD  input  32  write data
- O  output  32  read data, combinational from Addr[3:2]
- dip_switch  input  SW_W  raw switch levels, asynchronous; 1 = on
- user_key  input  KEY_W  raw keys, asynchronous, active-low (0 = pressed)
- irq  output  1  level interrupt request

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low on port reset. All state clears immediately when reset falls; release is sampled on the next clk edge.
- Synchronizer: every raw input passes a 2-flop synchronizer. user_key is inverted after synchronization, so internal 1 = pressed.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when count == TICK_DIV-1.
  - Free-running; unaffected by bus traffic.
- Debounce, per bit, on tick:
  - Shift the synchronized value into a DB_DEPTH-bit history.
  - If the history is all ones, the stable bit becomes 1; if all zeros, it becomes 0; otherwise the stable bit holds.
  - Minimum latency from a clean input change to a stable change: 2 + (DB_DEPTH-1)·TICK_DIV + up to TICK_DIV cycles.
- Press event: a stable key transition 0→1 sets event[i] in the same cycle the stable bit updates. Releases set nothing.
- Register map (Addr[3:2]):
  - 0 SW: stable switches, zero-extended; read-only.
  - 1 KEY: stable keys, 1 = pressed; read-only.
  - 2 EVT: sticky press events. Write-1-to-clear, per byte lane selected by byteen; writing 0 has no effect.
  - 3 CTRL: bit0 = irq_enable; bits [KEY_W+7:8] = per-key mask, limited to bit 31. Read/write per byte lane; unimplemented bits read 0.
- Writes to SW/KEY are ignored. Reads have no side effects.
- Simultaneous W1C and new event on the same bit in the same cycle: the set wins, and the bit stays 1.
- irq = CTRL.bit0 & |(EVT & mask). Registered, so it appears 1 cycle after the condition and deasserts 1 cycle after clearing.
- Reset values: O follows Addr (all registers 0); irq = 0; all histories, stable bits, EVT, CTRL and tick counter = 0.
- Reset mid-debounce discards partial history; no event is generated by release from reset.

Optional Feature:
- Macro: SWITCH_KEY_IRQ_EN.
- Defined: CTRL register and irq logic are present as described above.
- Undefined: CTRL reads 0 and writes are ignored; irq is tied to 0; EVT still records events for polling.

Decomposition:
- Shared package:
  - register offset constants (SW=0, KEY=1, EVT=2, CTRL=3 on Addr[3:2]);
  - CTRL bit positions (IRQ_EN=0, MASK_LSB=8).
- One natural sub-module: input_debouncer, parameterized by width and DB_DEPTH.
  - Contains the synchronizer, history registers and stable output; takes tick as input.
  - Instantiated twice, once for switches and once for keys.
- The tick counter, register file and irq logic stay in the top level.

Test Plan (TICK_DIV=4, DB_DEPTH=4):
- dip_switch: 0 → 32'hA5A5_0F0F held clean. SW reads 0 until ≤2+16 cycles after the change, then 32'hA5A5_0F0F. No change to EVT.
- user_key[3] low for 5 cycles (glitch), then high. KEY and EVT remain 0.
- user_key[3] held low 40 cycles. KEY=32'h8 and EVT=32'h8. After release and settle, KEY=0 and EVT stays 32'h8. Write EVT with WD=32'h8, byteen=4'hF; EVT reads 0.
- CTRL=32'h0000_0801 (enable, mask key3), then press key3. irq rises 1 cycle after EVT[3] sets. W1C of EVT drops irq the next cycle. With mask=0, irq stays 0.
- W1C of EVT[3] issued in the exact cycle a new press of key3 is accepted. EVT[3] reads 1.
- Assert reset (drive 0) asynchronously mid-debounce with EVT=32'h8 and CTRL set. All reads return 0 and irq=0 without a clk edge. After release, a held key produces a single event.
